// File: rtl/interrup_sequencer_if.sv
// Request/redirect bundle between the interrupt controller/CPU datapath and the sequencer.
interface interrup_sequencer_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned CW = 8
);
    logic          s_interrup;
    logic [AW-1:0] dir;
    logic [AW-1:0] pc_next;
    logic          reti;
    logic          pc_sel;
    logic [AW-1:0] pc_int;
    logic          fin;
    logic          in_service;
    logic [CW-1:0] int_count;
    logic          err_reti;
    logic          err_timeout;

    modport master (
        output s_interrup, dir, pc_next, reti,
        input  pc_sel, pc_int, fin, in_service, int_count, err_reti, err_timeout
    );

    modport slave (
        input  s_interrup, dir, pc_next, reti,
        output pc_sel, pc_int, fin, in_service, int_count, err_reti, err_timeout
    );
endinterface

// File: rtl/interrup_sequencer.sv
// CPU-side interrupt sequencer: vectors the PC on a request, restores it on reti,
// and closes the handshake with a one-cycle fin pulse. Supervises service time.
module interrup_sequencer #(
    parameter int unsigned AW      = 10,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CW      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    interrup_sequencer_if.slave   bus
);
    localparam int unsigned   WDW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_MAX   = {WDW{1'b1}};

    typedef enum logic [1:0] {IDLE, ENTER, SERVICE, RETURN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   vec_q, vec_d;
    logic [AW-1:0]   ret_q, ret_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            pc_sel_q, pc_sel_d;
    logic [AW-1:0]   pc_int_q, pc_int_d;
    logic            fin_q, fin_d;
    logic            in_service_q, in_service_d;
    logic [CW-1:0]   int_count_q, int_count_d;
    logic            err_reti_q, err_reti_d;
    logic            err_timeout_q, err_timeout_d;

    // Next state, then outputs derived from the state being entered so they register with it.
    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        ret_d         = ret_q;
        wd_d          = wd_q;
        pc_int_d      = pc_int_q;
        int_count_d   = int_count_q;
        err_timeout_d = err_timeout_q;
        err_reti_d    = err_reti_q | (bus.reti & (state_q != SERVICE));

        unique case (state_q)
            IDLE: begin
                if (bus.s_interrup) begin
                    vec_d   = bus.dir;
                    ret_d   = bus.pc_next;
                    state_d = ENTER;
                end
            end
            ENTER: begin
                wd_d    = '0;
                state_d = SERVICE;
            end
            SERVICE: begin
                // A reti on the timeout cycle wins: normal return, no error.
                if (bus.reti) begin
                    state_d = RETURN;
                end else if ((TIMEOUT != 0) && (wd_q == WD_LIMIT)) begin
                    err_timeout_d = 1'b1;
                    state_d       = RETURN;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RETURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pc_sel_d     = (state_d == ENTER) || (state_d == RETURN);
        fin_d        = (state_d == RETURN);
        in_service_d = (state_d != IDLE);
        if (state_d == ENTER) begin
            pc_int_d = vec_d;
        end
        if (state_d == RETURN) begin
            pc_int_d    = ret_q;
            int_count_d = int_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            vec_q         <= '0;
            ret_q         <= '0;
            wd_q          <= '0;
            pc_sel_q      <= 1'b0;
            pc_int_q      <= '0;
            fin_q         <= 1'b0;
            in_service_q  <= 1'b0;
            int_count_q   <= '0;
            err_reti_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            ret_q         <= ret_d;
            wd_q          <= wd_d;
            pc_sel_q      <= pc_sel_d;
            pc_int_q      <= pc_int_d;
            fin_q         <= fin_d;
            in_service_q  <= in_service_d;
            int_count_q   <= int_count_d;
            err_reti_q    <= err_reti_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.pc_sel      = pc_sel_q;
    assign bus.pc_int      = pc_int_q;
    assign bus.fin         = fin_q;
    assign bus.in_service  = in_service_q;
    assign bus.int_count   = int_count_q;
    assign bus.err_reti    = err_reti_q;
    assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_interrup_sequencer.sv
// Directed bench for interrup_sequencer; every PC redirect is checked against a scoreboard queue.
module tb_interrup_sequencer;
    localparam int unsigned AW      = 10;
    localparam int unsigned CW      = 8;
    localparam int unsigned TIMEOUT = 8;

    typedef struct packed {
        logic [AW-1:0] pc_int;
        logic          fin;
        logic [CW-1:0] cnt;
        logic          to;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interrup_sequencer_if #(.AW(AW), .CW(CW)) bus ();

    interrup_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] exp_cnt;
    logic          exp_to;
    logic [AW-1:0] cur_ret;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] pc, input logic f);
        exp_t e;
        e.pc_int = pc;
        e.fin    = f;
        e.cnt    = exp_cnt;
        e.to     = exp_to;
        exp_q.push_back(e);
    endtask

    // Request in IDLE; returns with ENTER visible.
    task automatic start_req(input logic [AW-1:0] d, input logic [AW-1:0] pc);
        bus.s_interrup = 1'b1;
        bus.dir        = d;
        bus.pc_next    = pc;
        cur_ret        = pc;
        push_exp(d, 1'b0);
        tick();
        bus.s_interrup = 1'b0;
        check("enter_in_service", 32'(bus.in_service), 32'd1);
    endtask

    task automatic service_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("service_sel", 32'({bus.pc_sel, bus.in_service, bus.fin}), 32'b010);
        end
    endtask

    // reti in SERVICE; returns with RETURN visible.
    task automatic do_ret();
        bus.reti = 1'b1;
        exp_cnt  = exp_cnt + 1'b1;
        push_exp(cur_ret, 1'b1);
        tick();
        bus.reti = 1'b0;
        check("return_fin", 32'(bus.fin), 32'd1);
    endtask

    task automatic idle_check(input string name);
        tick();
        check(name, 32'({bus.pc_sel, bus.fin, bus.in_service}), 32'd0);
    endtask

    // Scoreboard monitor: every redirect cycle must match the oldest expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (reset !== 1'b1 && bus.pc_sel === 1'b1) begin
            got = {bus.pc_int, bus.fin, bus.int_count, bus.err_timeout};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got redirect 0x%0h with no expectation at %0t", got, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_redirect", 32'(got), 32'(e));
            end
        end
        if (bus.fin === 1'b1) check("fin_needs_pc_sel", 32'(bus.pc_sel), 32'd1);
    end

    initial begin
        reset          = 1'b1;
        bus.s_interrup = 1'b0;
        bus.dir        = '0;
        bus.pc_next    = '0;
        bus.reti       = 1'b0;
        exp_cnt        = '0;
        exp_to         = 1'b0;
        cur_ret        = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("reset_outputs", 32'({bus.pc_sel, bus.pc_int, bus.fin, bus.in_service,
                                    bus.int_count, bus.err_reti, bus.err_timeout}), 32'd0);

        // Basic service, reti four cycles after the request.
        start_req(10'd984, 10'd37);
        service_ticks(3);
        do_ret();
        idle_check("idle_after_basic");
        check("no_err_reti_in_service", 32'(bus.err_reti), 32'd0);

        // reti on the very cycle the watchdog would fire: normal return.
        start_req(10'd100, 10'd200);
        service_ticks(TIMEOUT);
        do_ret();
        idle_check("idle_after_edge");
        check("edge_no_timeout", 32'(bus.err_timeout), 32'd0);

        // Watchdog: ENTER plus TIMEOUT SERVICE cycles, then forced return.
        start_req(10'd994, 10'd55);
        service_ticks(TIMEOUT);
        exp_cnt = exp_cnt + 1'b1;
        exp_to  = 1'b1;
        push_exp(10'd55, 1'b1);
        tick();
        check("timeout_fin", 32'({bus.fin, bus.pc_int, bus.err_timeout}), 32'({1'b1, 10'd55, 1'b1}));
        idle_check("idle_after_timeout");
        check("timeout_sticky", 32'(bus.err_timeout), 32'd1);

        // Stray reti while idle.
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        check("stray_reti", 32'({bus.err_reti, bus.fin, bus.pc_sel}), 32'b100);
        tick();
        check("err_reti_sticky", 32'(bus.err_reti), 32'd1);

        // Request during SERVICE and RETURN ignored; held request taken in the first IDLE cycle.
        start_req(10'd300, 10'd400);
        service_ticks(1);
        bus.s_interrup = 1'b1;
        bus.dir        = 10'd1004;
        bus.pc_next    = 10'd777;
        service_ticks(1);
        bus.s_interrup = 1'b0;
        service_ticks(1);
        do_ret();
        bus.s_interrup = 1'b1;
        bus.dir        = 10'd1004;
        bus.pc_next    = 10'd500;
        tick();
        check("idle_after_b2b_return", 32'({bus.in_service, bus.pc_sel}), 32'd0);
        start_req(10'd1004, 10'd500);
        service_ticks(2);
        do_ret();
        idle_check("idle_after_b2b");

        // Reset mid-service abandons everything without fin.
        start_req(10'd123, 10'd456);
        service_ticks(2);
        reset = 1'b1;
        tick();
        check("reset_mid_service", 32'({bus.pc_sel, bus.pc_int, bus.fin, bus.in_service,
                                        bus.int_count, bus.err_reti, bus.err_timeout}), 32'd0);
        reset   = 1'b0;
        exp_cnt = '0;
        exp_to  = 1'b0;
        tick();

        // Request and reti together in IDLE: taken, and flagged.
        bus.reti = 1'b1;
        start_req(10'd600, 10'd601);
        bus.reti = 1'b0;
        check("req_with_reti_err", 32'(bus.err_reti), 32'd1);
        service_ticks(1);
        do_ret();
        idle_check("idle_after_req_reti");

        // 2^CW more services: counter wraps back to its starting value.
        for (int i = 0; i < (1 << CW); i++) begin
            start_req(AW'(i * 3), AW'(i + 5));
            service_ticks(1);
            do_ret();
            tick();
        end
        check("count_wrapped", 32'(bus.int_count), 32'd1);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
